// File: rtl/rf_writeback_arbiter.sv
// Register-file writeback arbiter: per-source FIFOs feeding up to NUM_WP RF write ports
// with round-robin fairness and same-cycle address de-duplication. Optional bypass via RF_WB_FWD_EN.
module rf_writeback_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int NUM_WP  = 3,
  parameter int DEPTH   = 2,
  parameter int WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC-1:0]       in_valid,
  input  logic [NUM_SRC*6-1:0]     in_addr,
  input  logic [NUM_SRC*WIDTH-1:0] in_data,
  output logic [NUM_SRC-1:0]       in_ready,
  output logic [NUM_WP-1:0]        wen,
  output logic [NUM_WP*6-1:0]      waddr,
  output logic [NUM_WP*WIDTH-1:0]  wdata,
`ifdef RF_WB_FWD_EN
  output logic [NUM_WP-1:0]        fwd_valid,
  output logic [NUM_WP*6-1:0]      fwd_addr,
  output logic [NUM_WP*WIDTH-1:0]  fwd_data,
`endif
  output logic                     idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [5:0]       mem_addr [NUM_SRC][DEPTH];
  logic [WIDTH-1:0] mem_data [NUM_SRC][DEPTH];
  logic [PW-1:0]    wr_ptr   [NUM_SRC];
  logic [PW-1:0]    rd_ptr   [NUM_SRC];
  logic [CW-1:0]    count    [NUM_SRC];
  logic [SW-1:0]    rr_ptr;

  logic [5:0]       head_addr [NUM_SRC];
  logic [WIDTH-1:0] head_data [NUM_SRC];
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;

  logic [NUM_WP-1:0]       port_v;
  logic [NUM_WP*6-1:0]     port_addr;
  logic [NUM_WP*WIDTH-1:0] port_data;
  logic [SW-1:0]           rr_next;

  // in_ready depends only on occupancy, so a full FIFO never accepts even when popped.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      in_ready[s]  = (count[s] != CW'(DEPTH));
      push[s]      = in_valid[s] & in_ready[s];
      head_addr[s] = mem_addr[s][rd_ptr[s]];
      head_data[s] = mem_data[s][rd_ptr[s]];
    end
  end

  // Round-robin scan of FIFO heads; grants fill ports in order, addr 0 pops without a port.
  logic [SW-1:0] sidx;
  int            idx_i;
  logic          conflict;
  logic          placed;

  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    pop       = '0;
    port_v    = '0;
    port_addr = '0;
    port_data = '0;
    rr_next   = rr_ptr;
    sidx      = '0;
    idx_i     = 0;
    conflict  = 1'b0;
    placed    = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      idx_i = int'(rr_ptr) + j;
      if (idx_i >= NUM_SRC) idx_i = idx_i - NUM_SRC;
      sidx = SW'(idx_i);
      if (count[sidx] != '0) begin
        if (head_addr[sidx] == 6'd0) begin
          pop[sidx] = 1'b1;
          rr_next   = SW'((idx_i + 1) % NUM_SRC);
        end else if (!port_v[NUM_WP-1]) begin
          conflict = 1'b0;
          for (int p = 0; p < NUM_WP; p++) begin
            if (port_v[p] && (port_addr[p*6 +: 6] == head_addr[sidx])) conflict = 1'b1;
          end
          if (!conflict) begin
            placed = 1'b0;
            for (int p = 0; p < NUM_WP; p++) begin
              if (!placed && !port_v[p]) begin
                port_v[p]                  = 1'b1;
                port_addr[p*6 +: 6]        = head_addr[sidx];
                port_data[p*WIDTH +: WIDTH] = head_data[sidx];
                placed                     = 1'b1;
              end
            end
            pop[sidx] = 1'b1;
            rr_next   = SW'((idx_i + 1) % NUM_SRC);
          end
        end
      end
    end
  end

  // NOTE: FIFO storage carries no reset; occupancy counters alone decide what is valid.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (push[s]) begin
        mem_addr[s][wr_ptr[s]] <= in_addr[s*6 +: 6];
        mem_data[s][wr_ptr[s]] <= in_data[s*WIDTH +: WIDTH];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
      end
      rr_ptr <= '0;
      wen    <= '0;
      waddr  <= '0;
      wdata  <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + PW'(1);
        if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PW'(1);
        unique case ({push[s], pop[s]})
          2'b10:   count[s] <= count[s] + CW'(1);
          2'b01:   count[s] <= count[s] - CW'(1);
          default: count[s] <= count[s];
        endcase
      end
      if (|pop) rr_ptr <= rr_next;
      wen <= port_v;
      for (int p = 0; p < NUM_WP; p++) begin
        if (port_v[p]) begin
          waddr[p*6 +: 6]         <= port_addr[p*6 +: 6];
          wdata[p*WIDTH +: WIDTH] <= port_data[p*WIDTH +: WIDTH];
        end
      end
    end
  end

  logic any_busy;
  always_comb begin
    any_busy = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (count[s] != '0) any_busy = 1'b1;
    end
    idle = !any_busy && (wen == '0);
  end

`ifdef RF_WB_FWD_EN
  assign fwd_valid = port_v;
  assign fwd_addr  = port_addr;
  assign fwd_data  = port_data;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Self-checking bench for rf_writeback_arbiter: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_rf_writeback_arbiter;

  localparam int NUM_SRC = 4;
  localparam int NUM_WP  = 3;
  localparam int DEPTH   = 2;
  localparam int WIDTH   = 32;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_SRC-1:0]       in_valid;
  logic [NUM_SRC*6-1:0]     in_addr;
  logic [NUM_SRC*WIDTH-1:0] in_data;
  logic [NUM_SRC-1:0]       in_ready;
  logic [NUM_WP-1:0]        wen;
  logic [NUM_WP*6-1:0]      waddr;
  logic [NUM_WP*WIDTH-1:0]  wdata;
  logic                     idle;
`ifdef RF_WB_FWD_EN
  logic [NUM_WP-1:0]        fwd_valid;
  logic [NUM_WP*6-1:0]      fwd_addr;
  logic [NUM_WP*WIDTH-1:0]  fwd_data;
`endif

  always #5 clk = ~clk;

  rf_writeback_arbiter #(
    .NUM_SRC(NUM_SRC), .NUM_WP(NUM_WP), .DEPTH(DEPTH), .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
`ifdef RF_WB_FWD_EN
    .fwd_valid(fwd_valid),
    .fwd_addr (fwd_addr),
    .fwd_data (fwd_data),
`endif
    .idle     (idle)
  );

  typedef struct {
    logic [5:0]       addr;
    logic [WIDTH-1:0] data;
  } ent_t;

  ent_t             q [NUM_SRC][$];
  int               rr;
  logic [NUM_WP-1:0] e_wen;
  logic [5:0]       e_waddr [NUM_WP];
  logic [WIDTH-1:0] e_wdata [NUM_WP];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int s, input logic v, input logic [5:0] a, input logic [WIDTH-1:0] d);
    in_valid[s]              = v;
    in_addr[s*6 +: 6]        = a;
    in_data[s*WIDTH +: WIDTH] = d;
  endtask

  task automatic clear_inputs();
    in_valid = '0;
    in_addr  = '0;
    in_data  = '0;
  endtask

  // Advance one clock: update the model for the edge, then compare all outputs.
  task automatic step();
    logic [5:0]          gaddr [$];
    bit                  pushme [NUM_SRC];
    bit                  any;
    bit                  dup;
    int                  last;
    int                  s;
    ent_t                h;
    ent_t                ne;
    logic [NUM_SRC-1:0]  e_ready;
    logic [NUM_WP*6-1:0] e_flat_a;
    logic [NUM_WP*WIDTH-1:0] e_flat_d;
    bit                  e_idle;

    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) q[i].delete();
      rr    = 0;
      e_wen = '0;
      for (int p = 0; p < NUM_WP; p++) begin
        e_waddr[p] = '0;
        e_wdata[p] = '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) pushme[i] = in_valid[i] && (q[i].size() < DEPTH);
      any   = 0;
      last  = 0;
      e_wen = '0;
      for (int j = 0; j < NUM_SRC; j++) begin
        s = (rr + j) % NUM_SRC;
        if (q[s].size() > 0) begin
          h = q[s][0];
          if (h.addr == 6'd0) begin
            void'(q[s].pop_front());
            any = 1; last = s;
          end else if (gaddr.size() < NUM_WP) begin
            dup = 0;
            foreach (gaddr[g]) if (gaddr[g] == h.addr) dup = 1;
            if (!dup) begin
              e_wen[gaddr.size()]   = 1'b1;
              e_waddr[gaddr.size()] = h.addr;
              e_wdata[gaddr.size()] = h.data;
              gaddr.push_back(h.addr);
              void'(q[s].pop_front());
              any = 1; last = s;
            end
          end
        end
      end
      if (any) rr = (last + 1) % NUM_SRC;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (pushme[i]) begin
          ne.addr = in_addr[i*6 +: 6];
          ne.data = in_data[i*WIDTH +: WIDTH];
          q[i].push_back(ne);
        end
      end
    end

    @(posedge clk);
    @(negedge clk);

    e_idle = (e_wen == '0);
    for (int i = 0; i < NUM_SRC; i++) begin
      e_ready[i] = (q[i].size() < DEPTH);
      if (q[i].size() != 0) e_idle = 0;
    end
    for (int p = 0; p < NUM_WP; p++) begin
      e_flat_a[p*6 +: 6]         = e_waddr[p];
      e_flat_d[p*WIDTH +: WIDTH] = e_wdata[p];
    end
    check("in_ready", in_ready, e_ready);
    check("wen", wen, e_wen);
    check("waddr", waddr, e_flat_a);
    check("wdata", wdata, e_flat_d);
    check("idle", idle, e_idle);
    for (int p = 0; p < NUM_WP; p++)
      for (int r = p + 1; r < NUM_WP; r++)
        if (wen[p] && wen[r]) check("dup_waddr", waddr[p*6 +: 6] == waddr[r*6 +: 6], 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    rst_n = 1'b1;
  endtask

  bit seen_full0;

  initial begin
    rst_n = 1'b0;
    clear_inputs();

    // Reset held with every source valid: nothing may be accepted.
    for (int s = 0; s < NUM_SRC; s++) set_src(s, 1'b1, 6'(s + 1), $urandom);
    step();
    step();
    check("rst_ready", in_ready, 4'b1111);
    check("rst_wen", wen, 3'b000);
    check("rst_idle", idle, 1'b1);
    rst_n = 1'b1;
    clear_inputs();
    step();
    step();
    check("post_rst_idle", idle, 1'b1);
    check("post_rst_wen", wen, 3'b000);

    // Single write with two-cycle latency.
    set_src(1, 1'b1, 6'd5, 32'hDEADBEEF);
    step();
    check("single_latency_wen", wen, 3'b000);
    clear_inputs();
    step();
    check("single_wen", wen, 3'b001);
    check("single_waddr", waddr[5:0], 6'd5);
    check("single_wdata", wdata[31:0], 32'hDEADBEEF);
    step();
    check("single_idle", idle, 1'b1);

    // Same-address conflict from rr_ptr = 0.
    do_reset();
    set_src(0, 1'b1, 6'd9, 32'hAAAA0000);
    set_src(2, 1'b1, 6'd9, 32'hBBBB2222);
    step();
    clear_inputs();
    step();
    check("conf_a_wen", wen, 3'b001);
    check("conf_a_waddr", waddr[5:0], 6'd9);
    check("conf_a_wdata", wdata[31:0], 32'hAAAA0000);
    step();
    check("conf_b_wen", wen, 3'b001);
    check("conf_b_waddr", waddr[5:0], 6'd9);
    check("conf_b_wdata", wdata[31:0], 32'hBBBB2222);
    step();

    // Addr-0 pop moves rr_ptr to 0: src1 write leaves rr=2, src3 addr 0 wraps it to 0.
    do_reset();
    set_src(1, 1'b1, 6'd4, 32'h44);
    step();
    clear_inputs();
    step();
    set_src(3, 1'b1, 6'd0, 32'h1);
    step();
    clear_inputs();
    step();
    check("zero_wen", wen, 3'b000);
    check("zero_idle", idle, 1'b1);
    for (int s = 0; s < NUM_SRC; s++) set_src(s, 1'b1, 6'd11, 32'h100 + s);
    step();
    clear_inputs();
    step();
    check("zero_rr_winner_wen", wen, 3'b001);
    check("zero_rr_winner", wdata[31:0], 32'h100);
    for (int i = 0; i < 4; i++) step();

    // Oversubscription: distinct address ranges per source, three writes every cycle.
    do_reset();
    for (int c = 0; c < 24; c++) begin
      for (int s = 0; s < NUM_SRC; s++) set_src(s, 1'b1, 6'(s * 16 + 1 + (c % 15)), $urandom);
      step();
      if (c >= 2) check("oversub_count", $countones(wen), 3);
    end
    clear_inputs();
    for (int i = 0; i < 8; i++) step();

    // Backpressure then reset: buffered entries must never be written.
    do_reset();
    seen_full0 = 0;
    for (int c = 0; c < 6; c++) begin
      for (int s = 0; s < NUM_SRC; s++) set_src(s, 1'b1, 6'd20, 32'hC000 + c * 4 + s);
      step();
      if (!in_ready[0]) seen_full0 = 1;
    end
    check("bp_src0_full", seen_full0, 1'b1);
    do_reset();
    check("bp_rst_ready", in_ready, 4'b1111);
    check("bp_rst_idle", idle, 1'b1);
    for (int i = 0; i < 4; i++) step();

    // Random traffic with narrow address range to provoke conflicts and addr-0 entries.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int s = 0; s < NUM_SRC; s++)
        set_src(s, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1;
    clear_inputs();
    for (int i = 0; i < 10; i++) step();
    check("final_idle", idle, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
